// File: rtl/btb_bpred.sv
// Direct-mapped branch target buffer with a 2-bit saturating direction counter per entry.
// Looked up combinationally at Fetch, trained by the branch resolved in Decode.
module btb_bpred #(
  parameter int ENTRIES = 16,
  localparam int IDXW = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pcF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic [31:0] pcD,
  input  logic        branchD,
  input  logic        br_takenD,
  input  logic [31:0] branchimmD,
  output logic        BTBHitF,
  output logic        BpredF,
  output logic [31:0] branchimmF,
  output logic        BTBHitD,
  output logic        BpredD,
  output logic        mispredictD,
  output logic [31:0] mispred_cnt
);

  localparam int TAGW = 32 - IDXW - 2;

  logic [ENTRIES-1:0] r_valid;
  logic [TAGW-1:0]    r_tag [ENTRIES];
  logic [31:0]        r_imm [ENTRIES];
  logic [1:0]         r_ctr [ENTRIES];

  logic               r_hit_d;
  logic               r_pred_d;
  logic [31:0]        r_mispred_cnt;

  logic [IDXW-1:0]    w_idx_f;
  logic [IDXW-1:0]    w_idx_d;
  logic               w_hit_f;
  logic               w_hit_u;
  logic               w_upd;

  assign w_idx_f = pcF[IDXW+1:2];
  assign w_idx_d = pcD[IDXW+1:2];
  assign w_hit_f = r_valid[w_idx_f] && (r_tag[w_idx_f] == pcF[31:IDXW+2]);
  assign w_hit_u = r_valid[w_idx_d] && (r_tag[w_idx_d] == pcD[31:IDXW+2]);
  assign w_upd   = branchD & ~stallD;

  assign BTBHitF     = w_hit_f;
  assign BpredF      = w_hit_f & r_ctr[w_idx_f][1];
  assign branchimmF  = w_hit_f ? r_imm[w_idx_f] : 32'd0;
  assign BTBHitD     = r_hit_d;
  assign BpredD      = r_pred_d;
  assign mispredictD = branchD & ((r_hit_d & r_pred_d) != br_takenD);
  assign mispred_cnt = r_mispred_cnt;

  // Lookups read the pre-edge table, so a same-index lookup sees the old entry.
  // NOTE: the whole table is reset (not just valid) because stale tag/imm/ctr
  // must read as zero after reset; this costs a reset on every storage flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i] <= '0;
        r_imm[i] <= '0;
        r_ctr[i] <= 2'b00;
      end
    end else if (w_upd) begin
      if (w_hit_u) begin
        if (br_takenD) begin
          if (r_ctr[w_idx_d] != 2'b11) r_ctr[w_idx_d] <= r_ctr[w_idx_d] + 2'd1;
          r_imm[w_idx_d] <= branchimmD;
        end else if (r_ctr[w_idx_d] != 2'b00) begin
          r_ctr[w_idx_d] <= r_ctr[w_idx_d] - 2'd1;
        end
      end else if (br_takenD) begin
        r_valid[w_idx_d] <= 1'b1;
        r_tag[w_idx_d]   <= pcD[31:IDXW+2];
        r_imm[w_idx_d]   <= branchimmD;
        r_ctr[w_idx_d]   <= 2'b10;
      end
    end
  end

  // Flush beats stall so a squashed slot never carries a stale prediction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hit_d  <= 1'b0;
      r_pred_d <= 1'b0;
    end else if (flushD) begin
      r_hit_d  <= 1'b0;
      r_pred_d <= 1'b0;
    end else if (!stallD) begin
      r_hit_d  <= w_hit_f;
      r_pred_d <= BpredF;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mispred_cnt <= '0;
    end else if (mispredictD && !stallD) begin
      r_mispred_cnt <= r_mispred_cnt + 32'd1;
    end
  end

endmodule

// File: doc/btb_bpred.md
# btb_bpred

Branch target buffer and 2-bit direction predictor that sits upstream of `pc_gen`. It is looked up combinationally with the fetch PC and produces `BTBHitF`, `BpredF` and `branchimmF`. It registers the hit/predict bits into Decode as `BTBHitD`/`BpredD`. It is trained by the branch resolved in Decode (`branchD`, `br_takenD`, `branchimmD`). It also flags Decode-stage mispredictions and counts them for performance debug.

## Interface
- `ENTRIES`, 16, number of BTB entries; power of 2, ≥ 2; direct-mapped.
- `IDXW`, $clog2(ENTRIES), index width (derived, not overridden).
- `clk`  in  1  core clock.
- `reset`  in  1  asynchronous, active-high reset.
- `pcF`  in  32  fetch PC (lookup address).
- `stallD`  in  1  hold the F→D prediction register.
- `flushD`  in  1  clear the F→D prediction register.
- `pcD`  in  32  PC of the instruction in Decode.
- `branchD`  in  1  Decode instruction is a conditional branch.
- `br_takenD`  in  1  resolved branch outcome in Decode.
- `branchimmD`  in  32  resolved branch offset in Decode.
- `BTBHitF`  out  1  valid entry whose tag matches `pcF`.
- `BpredF`  out  1  predicted taken; counter MSB, 0 on miss.
- `branchimmF`  out  32  stored offset; 0 on miss.
- `BTBHitD`  out  1  registered `BTBHitF`.
- `BpredD`  out  1  registered `BpredF`.
- `mispredictD`  out  1  Decode branch outcome differs from the prediction it was fetched with.
- `mispred_cnt`  out  32  count of mispredictions.

## Operation
- Entry fields: `valid`, `tag[31:IDXW+2]`, `imm[31:0]`, `ctr[1:0]`. Index = `pc[IDXW+1:2]`. `pc[1:0]` is ignored.
- Lookup (combinational):
  - `BTBHitF = valid[idxF] & (tag[idxF] == pcF tag bits)`.
  - `BpredF = BTBHitF & ctr[idxF][1]`.
  - `branchimmF = BTBHitF ? imm[idxF] : 0`.
- Update enable: `upd = branchD & ~stallD`. The table is re-looked-up at `idxD` from `pcD`, giving `hitU`. The update is written at the posedge.
  - `hitU`, taken: `ctr` saturating increment (max 2'b11); `imm <= branchimmD`.
  - `hitU`, not taken: `ctr` saturating decrement (min 2'b00); `imm` unchanged.
  - Miss, taken: allocate (overwriting any resident entry): `valid=1`, `tag` from `pcD`, `imm=branchimmD`, `ctr=2'b10`.
  - Miss, not taken: no change.
- `mispredictD = branchD & ((BTBHitD & BpredD) != br_takenD)`. Combinational; not gated by `stallD`.
- `mispred_cnt` increments by 1 on each posedge where `mispredictD & ~stallD`. It wraps from 0xFFFF_FFFF to 0.
- F→D register, in priority order:
  - `reset` clears it.
  - `flushD` clears it to 0.
  - `stallD` holds it.
  - Otherwise it loads `BTBHitF`/`BpredF`.

## Timing
- Lookup latency 0 cycles. `BTBHitD`/`BpredD` are available 1 cycle after the `pcF` lookup.
- A table write at posedge N is visible to lookups from cycle N+1. There is no same-cycle write→read bypass: a lookup of the index being updated sees the old contents.
- A simultaneous lookup and update of the same index is legal; the update wins at the edge.
- `flushD` and `stallD` together: flush wins.
- `stallD` blocks table updates and counter increments, so a stalled branch trains exactly once.
- Reset (asynchronous, any time, including mid-update):
  - All `valid`, `ctr`, `tag` and `imm` fields go to 0.
  - `BTBHitD=0`, `BpredD=0`, `mispred_cnt=0`.
  - Combinational outputs go to 0 (`BTBHitF`, `BpredF`, `branchimmF`), and `mispredictD` is 0 unless `branchD & br_takenD`.
- Training requires the Decode prediction register to be valid. A flushed bubble has `branchD=0`, so it cannot train.

## Test plan
- **Reset then lookup:** after reset, lookup `pcF=0x100` → `BTBHitF=0`, `BpredF=0`, `branchimmF=0`, `mispred_cnt=0`.
- **Allocate:** `pcD=0x100`, `branchD=1`, `br_takenD=1`, `branchimmD=0x40` with `BTBHitD=0` → `mispredictD=1`. Next cycle lookup `pcF=0x100` → `BTBHitF=1`, `BpredF=1`, `branchimmF=0x40`; `mispred_cnt=1`.
- **Counter saturation:** 3 further taken updates at 0x100 → `ctr=2'b11`. Then 2 not-taken updates → `ctr=2'b01`, so `BpredF=0`. Then 2 more not-taken → `ctr` stays 2'b00 with the entry still valid.
- **Aliasing** (`ENTRIES=16`): allocate 0x100 (imm 0x40), then a taken branch at 0x140 (same index, different tag) with imm 0x80 → lookup 0x100 misses; lookup 0x140 hits with `branchimmF=0x80`.
- **Stall/flush:** hold `stallD=1` for 3 cycles with a taken branch in Decode → the table trains once and `mispred_cnt` increments once, after the stall drops. Assert `stallD` and `flushD` together → `BTBHitD=0`, `BpredD=0`.
- **Async reset mid-operation:** assert `reset` between edges during an update → the table and all registers clear immediately. After release, lookup 0x100 misses.
